// File: rtl/remote_comm_mb.sv
// rtl/remote_comm_mb.sv - multi-byte UART command/response engine (optional checksum byte: CHKSUM_EN)
module remote_comm_mb #(
  parameter int CMD_BYTES   = 3,
  parameter int RESP_BYTES  = 2,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [8*CMD_BYTES-1:0]  cmd,
  input  logic                    snd_cmd,
  output logic                    busy,
  output logic                    cmd_snt,
  output logic                    trmt,
  output logic [7:0]              tx_data,
  input  logic                    tx_done,
  input  logic                    rx_rdy,
  input  logic [7:0]              rx_data,
  output logic                    clr_rx_rdy,
  output logic [8*RESP_BYTES-1:0] resp,
  output logic                    resp_rdy,
  output logic                    timeout
);

`ifdef CHKSUM_EN
  localparam int TX_BYTES = CMD_BYTES + 1;
`else
  localparam int TX_BYTES = CMD_BYTES;
`endif
  localparam int BCW = (TX_BYTES > 1) ? $clog2(TX_BYTES) : 1;
  localparam int RCW = (RESP_BYTES > 1) ? $clog2(RESP_BYTES) : 1;
  localparam int TW  = $clog2(TIMEOUT_CYC);
  localparam logic [BCW-1:0] BC_LAST = BCW'(TX_BYTES - 1);
  localparam logic [RCW-1:0] RC_LAST = RCW'(RESP_BYTES - 1);
  localparam logic [TW-1:0]  TM_LAST = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, WAIT_TX, WAIT_RESP} state_t;

  state_t                  state, state_nxt;
  logic [8*TX_BYTES-1:0]   tx_sh, tx_sh_nxt, tx_ld, tx_shifted;
  logic [8*RESP_BYTES-1:0] rx_sh, rx_sh_nxt, rx_asm, resp_nxt;
  logic [BCW-1:0]          byte_cnt, byte_cnt_nxt;
  logic [RCW-1:0]          rcnt, rcnt_nxt;
  logic [TW-1:0]           timer, timer_nxt;
  logic [7:0]              tx_data_nxt;
  logic                    busy_nxt, cmd_snt_nxt, trmt_nxt, clr_nxt, resp_rdy_nxt, timeout_nxt;
  logic                    rx_acc;

  // Checksum byte rides at the LS end so it leaves after the command bytes.
  function automatic logic [8*TX_BYTES-1:0] tx_load(input logic [8*CMD_BYTES-1:0] c);
`ifdef CHKSUM_EN
    logic [7:0] s;
    s = '0;
    for (int i = 0; i < CMD_BYTES; i++) s = s + c[8*i +: 8];
    return {c, ~s};
`else
    return c;
`endif
  endfunction

  assign tx_ld      = tx_load(cmd);
  assign tx_shifted = tx_sh << 8;
  assign rx_asm     = (rx_sh << 8) | (8*RESP_BYTES)'(rx_data);
  // A held rx_rdy is only taken again once the clear pulse has gone out.
  assign rx_acc     = rx_rdy && !clr_rx_rdy;

  always_comb begin
    state_nxt    = state;
    tx_sh_nxt    = tx_sh;
    rx_sh_nxt    = rx_sh;
    byte_cnt_nxt = byte_cnt;
    rcnt_nxt     = rcnt;
    timer_nxt    = timer;
    tx_data_nxt  = tx_data;
    resp_nxt     = resp;
    cmd_snt_nxt  = cmd_snt;
    resp_rdy_nxt = resp_rdy;
    timeout_nxt  = timeout;
    trmt_nxt     = 1'b0;
    clr_nxt      = rx_acc;
    case (state)
      IDLE: begin
        if (snd_cmd) begin
          tx_sh_nxt    = tx_ld;
          tx_data_nxt  = tx_ld[8*TX_BYTES-1 -: 8];
          trmt_nxt     = 1'b1;
          cmd_snt_nxt  = 1'b0;
          resp_rdy_nxt = 1'b0;
          timeout_nxt  = 1'b0;
          byte_cnt_nxt = '0;
          state_nxt    = WAIT_TX;
        end
      end
      WAIT_TX: begin
        if (tx_done) begin
          if (byte_cnt != BC_LAST) begin
            tx_sh_nxt    = tx_shifted;
            tx_data_nxt  = tx_shifted[8*TX_BYTES-1 -: 8];
            trmt_nxt     = 1'b1;
            byte_cnt_nxt = byte_cnt + BCW'(1);
          end else begin
            cmd_snt_nxt = 1'b1;
            rcnt_nxt    = '0;
            timer_nxt   = '0;
            state_nxt   = WAIT_RESP;
          end
        end
      end
      WAIT_RESP: begin
        timer_nxt = timer + TW'(1);
        if (rx_acc) begin
          timer_nxt = '0;
          rx_sh_nxt = rx_asm;
          rcnt_nxt  = rcnt + RCW'(1);
          if (rcnt == RC_LAST) begin
            resp_nxt     = rx_asm;
            resp_rdy_nxt = 1'b1;
            state_nxt    = IDLE;
          end
        end else if (timer == TM_LAST) begin
          timeout_nxt = 1'b1;
          state_nxt   = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      tx_sh      <= '0;
      rx_sh      <= '0;
      byte_cnt   <= '0;
      rcnt       <= '0;
      timer      <= '0;
      tx_data    <= '0;
      resp       <= '0;
      busy       <= 1'b0;
      cmd_snt    <= 1'b0;
      trmt       <= 1'b0;
      clr_rx_rdy <= 1'b0;
      resp_rdy   <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      state      <= state_nxt;
      tx_sh      <= tx_sh_nxt;
      rx_sh      <= rx_sh_nxt;
      byte_cnt   <= byte_cnt_nxt;
      rcnt       <= rcnt_nxt;
      timer      <= timer_nxt;
      tx_data    <= tx_data_nxt;
      resp       <= resp_nxt;
      busy       <= busy_nxt;
      cmd_snt    <= cmd_snt_nxt;
      trmt       <= trmt_nxt;
      clr_rx_rdy <= clr_nxt;
      resp_rdy   <= resp_rdy_nxt;
      timeout    <= timeout_nxt;
    end
  end

endmodule

// File: doc/remote_comm_mb.md
Name: remote_comm_mb

Overview:
Parametrised multi-byte command/response engine for the remote-control UART link. It serialises a CMD_BYTES-wide command MS byte first into an external UART transmitter. It then collects RESP_BYTES response bytes from the UART receiver, with a response timeout. It sits between the command source (host FSM/bench) and the UART, replacing the fixed 2-byte-command / 1-byte-response sender.

Parameters:
CMD_BYTES, 3, command length in bytes (>=1)
RESP_BYTES, 2, response length in bytes (>=1)
TIMEOUT_CYC, 1000000, max idle clk cycles between response bytes before abort (>=2)

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
cmd  input  8*CMD_BYTES  command word; sampled only on accepted snd_cmd
snd_cmd  input  1  request to send cmd
busy  output  1  high whenever state != IDLE
cmd_snt  output  1  set when last command byte's tx_done seen; cleared on next accepted snd_cmd
trmt  output  1  one-cycle pulse starting a UART byte transmit
tx_data  output  8  byte to transmit; stable from trmt until tx_done
tx_done  input  1  UART transmit-complete pulse
rx_rdy  input  1  UART byte available (held until cleared)
rx_data  input  8  received byte
clr_rx_rdy  output  1  one-cycle pulse acknowledging rx_data
resp  output  8*RESP_BYTES  assembled response, first byte received in MS position
resp_rdy  output  1  full response valid; cleared on next accepted snd_cmd
timeout  output  1  response aborted by timeout; cleared on next accepted snd_cmd

Behaviour:
- Reset (rst high at clk edge, any state): state IDLE. busy, cmd_snt, trmt, clr_rx_rdy, resp_rdy, timeout all 0. resp=0, tx_data=0, counters 0. Reset mid-transfer aborts with no further trmt.
- All outputs registered.
- States: IDLE, WAIT_TX, WAIT_RESP.
- IDLE + snd_cmd (accepted): load cmd into tx shift reg; tx_data<=cmd MS byte; trmt<=1 next cycle (latency 1). Clear cmd_snt/resp_rdy/timeout; byte_cnt<=0; go WAIT_TX.
- snd_cmd while busy: ignored, cmd not sampled.
- WAIT_TX + tx_done:
  - byte_cnt < last: shift, tx_data<=next byte, trmt<=1, byte_cnt++.
  - Last byte: cmd_snt<=1, rcnt<=0, timer<=0, go WAIT_RESP.
- tx_done outside WAIT_TX: ignored.
- Byte acceptance rule (all states): byte accepted when rx_rdy && !clr_rx_rdy. Each accepted byte produces clr_rx_rdy=1 the next cycle, exactly one cycle, so a held rx_rdy is never double-counted.
- IDLE/WAIT_TX: accepted bytes are cleared and discarded (stray/early bytes).
- WAIT_RESP:
  - Timer increments each cycle and resets to 0 on each accepted byte.
  - Accepted byte shifts into internal resp shifter; rcnt++.
  - On last byte: resp<=assembled value, resp_rdy<=1, go IDLE.
  - Timer reaching TIMEOUT_CYC-1 with no byte that cycle: timeout<=1, go IDLE; resp keeps previous value; partial bytes dropped.
  - If the last byte and the timeout coincide, the byte wins.
- Counter widths: $clog2 of the respective limit, min 1.

Optional Feature:
Macro CHKSUM_EN.
- Defined: after the last cmd byte, one extra byte is sent, equal to ~(sum of cmd bytes mod 256). cmd_snt is set on that byte's tx_done. Response path is unchanged.
- Undefined: exactly CMD_BYTES bytes are sent.

Test Plan:
1. Defaults, cmd=24'hA55AC3, snd_cmd pulse; bench UART returns tx_done 50 cycles after each trmt -> three trmt pulses with tx_data A5, 5A, C3 in order; cmd_snt rises 1 cycle after 3rd tx_done; busy high throughout.
2. After test 1, bench presents rx_data 8'h12 then 8'h34, each held until clr_rx_rdy -> exactly two clr_rx_rdy pulses; resp=16'h1234; resp_rdy=1; busy=0; timeout=0.
3. TIMEOUT_CYC=100, send cmd, supply one response byte then nothing -> timeout=1 exactly 100 cycles after the byte acceptance; resp_rdy=0; resp unchanged from previous; state IDLE; next snd_cmd clears timeout.
4. snd_cmd pulsed with cmd=24'h000001 while in WAIT_TX of an earlier 24'hA55AC3 transfer -> ignored; transmitted bytes still A5, 5A, C3; only 3 trmt pulses.
5. Assert rst for 1 cycle after 2nd tx_done -> next cycle all outputs 0, no further trmt; stray rx_rdy in IDLE then gets one clr_rx_rdy and resp stays 0.
6. CHKSUM_EN defined, cmd=24'hA55AC3 -> four bytes A5, 5A, C3, 3D; cmd_snt after 4th tx_done.
